image_line_feeder: RTL and testbench
====================================

# image_line_feeder

Upstream pacing stage for `imageProcessTop`. It takes a raw 8-bit grayscale pixel stream from a source with a valid/ready handshake, such as a DMA or BMP reader. It forwards that stream to the filter's slave interface using the line-credit protocol the filter requires:
- prime the line buffers with `PRIME_LINES` rows;
- then send exactly one row per rising edge of the filter's interrupt;
- then send `FLUSH_LINES` rows of zeros so the last image rows reach the filter output.

## Interface
Parameters:
- `IMG_WIDTH`, 512, pixels per row.
- `IMG_HEIGHT`, 512, image rows taken from the source.
- `PRIME_LINES`, 4, rows sent before the first credit is needed.
- `FLUSH_LINES`, 2, zero rows appended after the image.
- `DATA_WIDTH`, 8, pixel width.

Ports:
- `axi_clk`  in  1  single clock; everything is sampled on the rising edge.
- `axi_reset`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  one-cycle pulse that starts a frame; ignored while `o_busy`=1.
- `s_data_valid`  in  1  source pixel valid.
- `s_data`  in  `DATA_WIDTH`  source pixel.
- `s_data_ready`  out  1  feeder accepts a source pixel this cycle.
- `o_data_valid`  out  1  pixel to the filter is valid.
- `o_data`  out  `DATA_WIDTH`  pixel to the filter.
- `i_data_ready`  in  1  filter accepts the pixel.
- `i_intr`  in  1  filter interrupt (level); each rising edge is one line credit.
- `o_busy`  out  1  frame in progress.
- `o_done`  out  1  one-cycle pulse when the last flush pixel is accepted downstream.

## Operation
- FSM states: IDLE, SEND, WAIT, DRAIN.
  - IDLE + `i_start` → SEND. Clears the line counter, pixel counter and credit counter.
  - SEND: one pixel is loaded into the output register per load event.
    - Image row (`line` < `IMG_HEIGHT`): a load event is a source handshake, `s_data_valid && s_data_ready`.
    - Flush row: the pixel is generated internally with value 0, and the source is never touched.
    - `s_data_ready` = (state==SEND) && image row && (!`o_data_valid` || `i_data_ready`). Flush loads use the same output-register condition.
  - Row end (load of pixel `IMG_WIDTH`-1): `line` increments.
    - If the new `line` equals `IMG_HEIGHT`+`FLUSH_LINES` → DRAIN.
    - Else if the new `line` < `PRIME_LINES` → stay in SEND.
    - Else → WAIT.
  - WAIT: when `credit` > 0, decrement `credit` and go to SEND. Zero idle cycles are required when credit is already available.
  - DRAIN: when the output register empties (handshake on the final pixel), pulse `o_done` and go to IDLE.
- Credit counter: 3 bits, saturates at 7.
  - Increments on each `i_intr` rising edge, detected against a registered copy of `i_intr`, in states SEND, WAIT and DRAIN. Edges in IDLE are ignored.
  - A simultaneous increment and decrement leaves the count unchanged.
- Output register: a single stage.
  - Holds `o_data`/`o_data_valid` stable while `o_data_valid && !i_data_ready`.
  - Drains in every state.
- Pixel counter: 0..`IMG_WIDTH`-1, wraps to 0 at row end.
- Line counter: 0..`IMG_HEIGHT`+`FLUSH_LINES`.
- `o_busy` = (state != IDLE).
- Per frame: the source supplies exactly `IMG_WIDTH`×`IMG_HEIGHT` pixels; downstream receives `IMG_WIDTH`×(`IMG_HEIGHT`+`FLUSH_LINES`) pixels, in source order followed by zeros.

## Timing
- Reset values: `s_data_ready`=0, `o_data_valid`=0, `o_data`=0, `o_busy`=0, `o_done`=0. State=IDLE and all counters are 0.
- Reset is asynchronous: outputs go to their reset values immediately on assertion. Reset mid-frame discards the in-flight pixel and all credits.
- Start latency: `i_start` at cycle N → state SEND at N+1 → `s_data_ready` can be 1 at N+1.
- Pixel latency: a source handshake at cycle N → `o_data_valid`=1 carrying that pixel at N+1.
- Full throughput is 1 pixel/cycle with both sides always ready, including across row boundaries when credit is available.
- `i_intr` held high for many cycles counts as one credit. Credits may arrive before they are needed, including during priming.

## Test plan
- Prime: `i_start`, source always valid with an incrementing byte pattern, `i_data_ready`=1, no `i_intr` → exactly 2048 downstream beats in order, then `s_data_ready` held at 0 and WAIT persists.
- Credit: after priming, one `i_intr` pulse held high for 10 cycles → exactly 512 more beats, back to back, then the feeder stalls again.
- Early credit: two `i_intr` pulses during priming → rows 5 and 6 follow row 4 with zero gap cycles (2048+1024 contiguous beats).
- Backpressure: `i_data_ready` random at 50% throughout a full frame → `o_data` stable while stalled, and the received stream equals the source stream exactly (no loss, no duplicates).
- Flush/done: full 512×512 frame with an `i_intr` pulse after each row → 262144 source handshakes, then 1024 zero beats, total 263168 beats. `o_done` is high for exactly 1 cycle and `o_busy` falls on the same edge.
- Reset mid-row: assert `axi_reset` during row 5 → `o_data_valid`/`s_data_ready`/`o_busy` drop to 0 without waiting for a clock. After release, `i_start` triggers a fresh 2048-beat prime that needs no credits, and any credit pending before reset is not used.

Source files
------------

// File: rtl/image_line_feeder.sv
// Paces a valid/ready pixel source into a line-credit consumer: primes rows, one row per credit, then zero flush rows.
// Latency: one cycle source-to-output through a single output register; full rate when credit is banked.
module image_line_feeder #(
  parameter int IMG_WIDTH   = 512,
  parameter int IMG_HEIGHT  = 512,
  parameter int PRIME_LINES = 4,
  parameter int FLUSH_LINES = 2,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic                  i_start,
  input  logic                  s_data_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_data_ready,
  output logic                  o_data_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_data_ready,
  input  logic                  i_intr,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int PW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int LW = $clog2(IMG_HEIGHT + FLUSH_LINES + 1);
  localparam logic [PW-1:0] PIX_LAST   = PW'(IMG_WIDTH - 1);
  localparam logic [LW-1:0] LINE_END   = LW'(IMG_HEIGHT + FLUSH_LINES);
  localparam logic [LW-1:0] LINE_IMG   = LW'(IMG_HEIGHT);
  localparam logic [LW-1:0] LINE_PRIME = LW'(PRIME_LINES);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DRAIN} state_t;

  state_t                r_state;
  logic [PW-1:0]         r_pix;
  logic [LW-1:0]         r_line;
  logic [2:0]            r_credit;
  logic                  r_intr_q;
  logic                  r_ovld;
  logic [DATA_WIDTH-1:0] r_odata;
  logic                  r_done;

  logic          w_img_row;
  logic          w_out_free;
  logic          w_load;
  logic          w_row_end;
  logic [LW-1:0] w_line_nxt;
  logic          w_need_credit;
  logic          w_intr_rise;
  logic          w_seamless;
  logic          w_dec;

  assign w_img_row     = (r_line < LINE_IMG);
  assign w_out_free    = !r_ovld || i_data_ready;
  assign w_load        = (r_state == SEND) && w_out_free && (s_data_valid || !w_img_row);
  assign w_row_end     = w_load && (r_pix == PIX_LAST);
  assign w_line_nxt    = r_line + LW'(1);
  assign w_need_credit = (w_line_nxt != LINE_END) && (w_line_nxt >= LINE_PRIME);
  assign w_intr_rise   = i_intr && !r_intr_q && (r_state != IDLE);
  // A banked credit at row end is spent immediately so the next row follows with no gap.
  assign w_seamless    = w_row_end && w_need_credit && (r_credit != 3'd0);
  assign w_dec         = w_seamless || ((r_state == WAIT) && (r_credit != 3'd0));

  assign s_data_ready = (r_state == SEND) && w_img_row && w_out_free;
  assign o_data_valid = r_ovld;
  assign o_data       = r_odata;
  assign o_busy       = (r_state != IDLE);
  assign o_done       = r_done;

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_state  <= IDLE;
      r_pix    <= '0;
      r_line   <= '0;
      r_credit <= '0;
      r_intr_q <= 1'b0;
      r_ovld   <= 1'b0;
      r_odata  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_intr_q <= i_intr;
      r_done   <= (r_state == DRAIN) && r_ovld && i_data_ready;

      if (w_load) begin
        r_ovld  <= 1'b1;
        r_odata <= w_img_row ? s_data : '0;
      end else if (i_data_ready) begin
        r_ovld  <= 1'b0;
      end

      if (r_state == IDLE)
        r_credit <= '0;
      else if (w_intr_rise && !w_dec)
        r_credit <= (r_credit == 3'd7) ? 3'd7 : r_credit + 3'd1;
      else if (!w_intr_rise && w_dec)
        r_credit <= r_credit - 3'd1;

      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= SEND;
            r_line  <= '0;
            r_pix   <= '0;
          end
        end
        SEND: begin
          if (w_load) begin
            r_pix <= w_row_end ? '0 : r_pix + PW'(1);
            if (w_row_end) begin
              r_line <= w_line_nxt;
              if (w_line_nxt == LINE_END)
                r_state <= DRAIN;
              else if (w_need_credit && (r_credit == 3'd0))
                r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_credit != 3'd0)
            r_state <= SEND;
        end
        DRAIN: begin
          if (r_ovld && i_data_ready)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_line_feeder.sv
// Randomized bench for image_line_feeder on a reduced 8x8 image; the reference is an
// ordered queue of expected beats plus a row-credit count of how many beats are allowed.
module tb_image_line_feeder;
  localparam int W = 8;
  localparam int H = 8;
  localparam int P = 4;
  localparam int F = 2;

  logic       axi_clk = 1'b0;
  logic       axi_reset;
  logic       i_start;
  logic       s_data_valid;
  logic [7:0] s_data;
  logic       s_data_ready;
  logic       o_data_valid;
  logic [7:0] o_data;
  logic       i_data_ready;
  logic       i_intr;
  logic       o_busy;
  logic       o_done;

  image_line_feeder #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PRIME_LINES(P), .FLUSH_LINES(F), .DATA_WIDTH(8)
  ) dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset), .i_start(i_start),
    .s_data_valid(s_data_valid), .s_data(s_data), .s_data_ready(s_data_ready),
    .o_data_valid(o_data_valid), .o_data(o_data), .i_data_ready(i_data_ready),
    .i_intr(i_intr), .o_busy(o_busy), .o_done(o_done)
  );

  initial forever #5 axi_clk = ~axi_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] cur_pix;
  int  src_pct, dn_pct;
  logic start_req, intr_lvl;
  int  cyc, src_cnt, dn_cnt, done_cnt;
  int  first_cyc, last_cyc, beats_ph;
  logic prev_stall, prev_busy;
  logic [7:0] prev_data;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beats the consumer may receive after a given number of credits: primed rows plus one row per credit.
  function automatic int allowed_beats(int credits);
    int rows;
    rows = P + credits;
    if (rows > H + F) rows = H + F;
    return W * rows;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    src_cnt = 0; dn_cnt = 0; done_cnt = 0;
    prev_stall = 1'b0; prev_busy = 1'b0;
    first_cyc = -1; last_cyc = -1; beats_ph = 0;
  endtask

  task automatic mark();
    first_cyc = -1; last_cyc = -1; beats_ph = 0;
  endtask

  task automatic tick();
    @(negedge axi_clk);
    i_start      = start_req;
    i_intr       = intr_lvl;
    s_data_valid = ($urandom_range(99) < src_pct);
    s_data       = cur_pix;
    i_data_ready = ($urandom_range(99) < dn_pct);
    #1;
    cyc++;
    if (prev_stall) begin
      chk("hold_valid", {31'd0, o_data_valid}, 32'd1);
      chk("hold_data", {24'd0, o_data}, {24'd0, prev_data});
    end
    if (o_done) begin
      done_cnt++;
      chk("busy_low_with_done", {31'd0, o_busy}, 32'd0);
      chk("busy_high_before_done", {31'd0, prev_busy}, 32'd1);
    end
    prev_busy = o_busy;
    if (o_data_valid && i_data_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {24'd0, o_data}, 32'hFFFF_FFFF);
      end else begin
        chk("beat_data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
      end
      dn_cnt++;
      beats_ph++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end
    if (s_data_valid && s_data_ready) begin
      exp_q.push_back(s_data);
      src_cnt++;
      cur_pix = 8'($urandom);
      if (src_cnt == W * H)
        for (int k = 0; k < W * F; k++) exp_q.push_back(8'd0);
    end
    prev_stall = o_data_valid && !i_data_ready;
    prev_data  = o_data;
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic start_frame();
    clear_model();
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
  endtask

  task automatic pulse_intr(int hi, int lo);
    intr_lvl = 1'b1;
    ticks(hi);
    intr_lvl = 1'b0;
    ticks(lo);
  endtask

  initial begin
    axi_reset = 1'b1; i_start = 1'b0; s_data_valid = 1'b0; s_data = '0;
    i_data_ready = 1'b0; i_intr = 1'b0;
    start_req = 1'b0; intr_lvl = 1'b0; src_pct = 100; dn_pct = 100;
    cur_pix = 8'($urandom); cyc = 0;
    clear_model();
    #1;
    chk("rst_s_data_ready", {31'd0, s_data_ready}, 32'd0);
    chk("rst_o_data_valid", {31'd0, o_data_valid}, 32'd0);
    chk("rst_o_data", {24'd0, o_data}, 32'd0);
    chk("rst_o_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_o_done", {31'd0, o_done}, 32'd0);
    ticks(2);
    axi_reset = 1'b0;
    ticks(2);

    // Prime with no credits: exactly P rows, contiguous, then stalled in place.
    start_frame();
    mark();
    ticks(60);
    chk("prime_beats", dn_cnt, allowed_beats(0));
    chk("prime_contig", last_cyc - first_cyc + 1, beats_ph);
    chk("prime_src", src_cnt, allowed_beats(0));
    chk("prime_ready_low", {31'd0, s_data_ready}, 32'd0);
    ticks(20);
    chk("prime_still_waiting", dn_cnt, allowed_beats(0));
    chk("prime_busy", {31'd0, o_busy}, 32'd1);

    // A long interrupt level is one credit: one more row, back to back.
    mark();
    pulse_intr(10, 40);
    chk("credit_beats", dn_cnt, allowed_beats(1));
    chk("credit_row_contig", last_cyc - first_cyc + 1, beats_ph);
    chk("credit_row_len", beats_ph, W);
    chk("credit_ready_low", {31'd0, s_data_ready}, 32'd0);

    // Two edges: one starts the next row, the other is banked when reset hits mid-row.
    pulse_intr(1, 1);
    pulse_intr(1, 1);
    #2;
    axi_reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, o_data_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, s_data_ready}, 32'd0);
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("mid_rst_data", {24'd0, o_data}, 32'd0);
    ticks(2);
    axi_reset = 1'b0;
    clear_model();
    ticks(2);

    // Fresh prime after reset: the banked credit must be gone.
    start_frame();
    ticks(70);
    chk("reprime_beats", dn_cnt, allowed_beats(0));
    chk("reprime_ready_low", {31'd0, s_data_ready}, 32'd0);

    axi_reset = 1'b1;
    ticks(2);
    axi_reset = 1'b0;
    clear_model();
    ticks(2);

    // Early credits during priming: two extra rows follow with no gap.
    start_frame();
    mark();
    ticks(4);
    pulse_intr(2, 2);
    pulse_intr(2, 2);
    ticks(70);
    chk("early_beats", dn_cnt, allowed_beats(2));
    chk("early_contig", last_cyc - first_cyc + 1, beats_ph);
    chk("early_ready_low", {31'd0, s_data_ready}, 32'd0);

    // Rest of the frame under random backpressure and a bursty source.
    dn_pct = 50; src_pct = 70;
    for (int r = 0; r < H + F - P - 2; r++) pulse_intr(3, 30);
    for (int k = 0; k < 2000 && done_cnt == 0; k++) tick();
    ticks(5);
    chk("frame_done_once", done_cnt, 1);
    chk("frame_total_beats", dn_cnt, W * (H + F));
    chk("frame_src_count", src_cnt, W * H);
    chk("frame_queue_empty", exp_q.size(), 0);
    chk("frame_busy_low", {31'd0, o_busy}, 32'd0);
    chk("frame_valid_low", {31'd0, o_data_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
